// File: rtl/frame_scheduler_pkg.sv
// Shared game package: scheduler FSM states, 640x480 VGA timing constants and update stage indices.
package frame_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  // 640x480 @ 60 Hz timing, shared with the VGA timing generator
  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE_ROW = 480;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned H_FP_START   = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_BP_START   = 752;
  localparam int unsigned V_FP_START   = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_BP_START   = 492;

  localparam int unsigned STG_INPUT  = 0;
  localparam int unsigned STG_PADDLE = 1;
  localparam int unsigned STG_BALL   = 2;
  localparam int unsigned STG_BRICKS = 3;

endpackage

// File: rtl/frame_event_decode.sv
// Decodes blanking-start and active-video-start events from the timing generator's pixel counters.
module frame_event_decode
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned V_ACTIVE = V_FP_START
) (
  input  logic [9:0] x_count,
  input  logic [9:0] y_count,
  output logic       vb_start_c,
  output logic       av_start_c
);

  assign vb_start_c = (x_count == 10'd0) && (y_count == 10'(V_ACTIVE));
  assign av_start_c = (x_count == 10'd0) && (y_count == 10'd0);

endmodule

// File: rtl/frame_scheduler.sv
// Runs the per-frame update stages in order during vertical blanking using a one-hot req/ack handshake.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned V_ACTIVE   = V_FP_START,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned FC_W       = 16
) (
  input  logic                  VGA_clk,
  input  logic                  reset,
  input  logic [9:0]            xCount,
  input  logic [9:0]            yCount,
  input  logic [NUM_STAGES-1:0] stageAck,
  output logic [NUM_STAGES-1:0] stageReq,
  output logic                  busy,
  output logic                  frameStart,
  output logic [FC_W-1:0]       frameCount,
  output logic                  timeoutErr,
  output logic                  overrun
);

  localparam int unsigned STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

  sched_state_e          state_q, state_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [NUM_STAGES-1:0] stage_req_q, stage_req_d;
  logic                  busy_q, busy_d;
  logic                  frame_start_q, frame_start_d;
  logic [FC_W-1:0]       frame_count_q, frame_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  overrun_q, overrun_d;

  logic vb_start_c;
  logic av_start_c;
  logic ack_c;
  logic last_c;

  frame_event_decode #(
    .V_ACTIVE(V_ACTIVE)
  ) u_decode (
    .x_count   (xCount),
    .y_count   (yCount),
    .vb_start_c(vb_start_c),
    .av_start_c(av_start_c)
  );

  assign ack_c  = stageAck[stage_q];
  assign last_c = (stage_q == LAST_STG);

  // Next state; a last-stage ack beats avStart, otherwise avStart beats ack and timeout
  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    tmr_d         = tmr_q;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    frame_start_d = vb_start_c;
    frame_count_d = vb_start_c ? frame_count_q + FC_W'(1) : frame_count_q;

    unique case (state_q)
      IDLE: begin
        if (vb_start_c) begin
          state_d = REQ;
          stage_d = '0;
          tmr_d   = '0;
        end
      end
      REQ: begin
        if (ack_c && last_c) begin
          state_d = GAP;
        end else if (av_start_c) begin
          state_d   = IDLE;
          stage_d   = '0;
          overrun_d = 1'b1;
        end else if (ack_c) begin
          state_d = GAP;
        end else if (tmr_q == TMR_MAX) begin
          state_d       = GAP;
          timeout_err_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      GAP: begin
        if (av_start_c) begin
          state_d   = IDLE;
          stage_d   = '0;
          overrun_d = 1'b1;
        end else if (last_c) begin
          state_d = IDLE;
          stage_d = '0;
        end else begin
          state_d = REQ;
          stage_d = stage_q + STG_W'(1);
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase

    stage_req_d = (state_d == REQ) ? (NUM_STAGES'(1) << stage_d) : '0;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      tmr_q         <= '0;
      stage_req_q   <= '0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      tmr_q         <= tmr_d;
      stage_req_q   <= stage_req_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign stageReq   = stage_req_q;
  assign busy       = busy_q;
  assign frameStart = frame_start_q;
  assign frameCount = frame_count_q;
  assign timeoutErr = timeout_err_q;
  assign overrun    = overrun_q;

endmodule
